// File: rtl/acc_bram_mc_pkg.sv
// Shared types and constants for the multi-channel accumulating block RAM.
package acc_bram_mc_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int DROP_W = 16;

endpackage

// File: rtl/acc_bram_unit.sv
// One accumulating bin RAM: S0 read, S1 saturating add and write-back, with
// forwarding of the previous sum for back-to-back hits on the same bin.
module acc_bram_unit
  import acc_bram_mc_pkg::*;
#(
  parameter int datBit  = 17,
  parameter int addrBit = 9,
  parameter int incBit  = 3
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             i_run,
  input  logic             i_swp_we,
  input  logic [addrBit:0] i_swp_a,
  input  logic             i_inc_v,
  input  logic [addrBit:0] i_inc_a,
  input  logic [incBit:0]  i_inc_d,
  input  logic             i_rd_en,
  input  logic [addrBit:0] i_rd_a,
  output logic [datBit:0]  o_q,
  output logic             o_s1_v
);

  localparam int DEPTH = 2 ** (addrBit + 1);

  logic [datBit:0]  r_mem [DEPTH];
  logic [datBit:0]  r_q;
  logic [datBit:0]  r_sum;
  logic             r_s1_v;
  logic             r_fwd;
  logic [addrBit:0] r_s1_a;
  logic [incBit:0]  r_s1_d;

  logic             w_s0_v;
  logic [addrBit:0] w_rd_addr;
  logic [datBit:0]  w_old;
  logic [datBit+1:0] w_ext;
  logic [datBit:0]  w_sum;

  assign w_s0_v    = i_inc_v & i_run;
  assign w_rd_addr = i_rd_en ? i_rd_a : i_inc_a;
  // The RAM read issued while S1 writes the same bin is stale; use last sum.
  assign w_old     = r_fwd ? r_sum : r_q;
  assign w_ext     = {1'b0, w_old} + {{(datBit + 1 - incBit){1'b0}}, r_s1_d};
  assign w_sum     = w_ext[datBit+1] ? '1 : w_ext[datBit:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which the forwarding compare depends on.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_s1_v <= 1'b0;
      r_fwd  <= 1'b0;
      r_s1_a <= '0;
      r_s1_d <= '0;
      r_sum  <= '0;
    end else begin
      r_s1_v <= w_s0_v;
      r_s1_a <= i_inc_a;
      r_s1_d <= i_inc_d;
      r_fwd  <= w_s0_v & r_s1_v & (i_inc_a == r_s1_a);
      r_sum  <= w_sum;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; the zero
  // sweep clears it instead. The sweep write is last so it wins a collision.
  always_ff @(posedge clk) begin
    r_q <= r_mem[w_rd_addr];
    if (r_s1_v)   r_mem[r_s1_a]  <= w_sum;
    if (i_swp_we) r_mem[i_swp_a] <= '0;
  end

  assign o_q    = r_q;
  assign o_s1_v = r_s1_v;

endmodule

// File: rtl/acc_bram_mc.sv
// Multi-channel accumulating block RAM: sweep FSM, drop counter and readout
// arbitration around totUnits+1 independent accumulating units.
module acc_bram_mc
  import acc_bram_mc_pkg::*;
#(
  parameter int datBit   = 17,
  parameter int addrBit  = 9,
  parameter int incBit   = 3,
  parameter int totUnits = 31
) (
  input  logic                                  clk,
  input  logic                                  RSTn,
  input  logic                                  clr,
  input  logic [totUnits:0]                     inc_v,
  input  logic [(addrBit+1)*(totUnits+1)-1:0]   inc_a,
  input  logic [(incBit+1)*(totUnits+1)-1:0]    inc_d,
  input  logic                                  rd_v,
  input  logic [addrBit:0]                      rd_a,
  output logic                                  rd_rdy,
  output logic                                  rd_dv,
  output logic [(datBit+1)*(totUnits+1)-1:0]    rd_d,
  output logic                                  busy,
  output logic [DROP_W-1:0]                     drop_cnt
);

  state_e           r_state, w_state_nxt;
  logic [addrBit:0] r_cnt, w_cnt_nxt;
  logic [DROP_W-1:0] r_drop;
  logic             r_rd_dv;

  logic             w_run;
  logic             w_swp;
  logic             w_rd_en;
  logic [totUnits:0] w_s1_v;
  logic [DROP_W:0]  w_pop;
  logic [DROP_W:0]  w_drop_sum;
  logic [(datBit+1)*(totUnits+1)-1:0] w_q;

  assign w_run   = (r_state == RUN);
  assign w_swp   = (r_state == SWEEP);
  assign rd_rdy  = w_run & ~(|inc_v) & ~(|w_s1_v);
  assign w_rd_en = rd_v & rd_rdy;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      SWEEP: begin
        if (clr) begin
          w_cnt_nxt = '0;
        end else if (&r_cnt) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = SWEEP;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int u = 0; u <= totUnits; u++) w_pop = w_pop + (DROP_W + 1)'(inc_v[u]);
    w_drop_sum = {1'b0, r_drop} + w_pop;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_drop  <= '0;
      r_rd_dv <= 1'b0;
    end else begin
      r_rd_dv <= w_rd_en;
      if (w_swp && (|inc_v))
        r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end
  end

  for (genvar u = 0; u <= totUnits; u++) begin : g_unit
    acc_bram_unit #(
      .datBit (datBit),
      .addrBit(addrBit),
      .incBit (incBit)
    ) u_unit (
      .clk     (clk),
      .RSTn    (RSTn),
      .i_run   (w_run),
      .i_swp_we(w_swp),
      .i_swp_a (r_cnt),
      .i_inc_v (inc_v[u]),
      .i_inc_a (inc_a[u*(addrBit+1) +: addrBit+1]),
      .i_inc_d (inc_d[u*(incBit+1) +: incBit+1]),
      .i_rd_en (w_rd_en),
      .i_rd_a  (rd_a),
      .o_q     (w_q[u*(datBit+1) +: datBit+1]),
      .o_s1_v  (w_s1_v[u])
    );
  end

  // Readout words are only meaningful alongside rd_dv; hold zero otherwise.
  assign rd_d     = r_rd_dv ? w_q : '0;
  assign rd_dv    = r_rd_dv;
  assign busy     = w_swp;
  assign drop_cnt = r_drop;

endmodule

// File: doc/acc_bram_mc.md
Name: acc_bram_mc

Overview:
- Multi-channel accumulating block RAM: a parametrised successor to the plain and self-clearing dual-port bRAM arrays.
- Each of totUnits+1 independent units holds 2^(addrBit+1) bins and performs a pipelined, saturating read-modify-write for every increment request.
- Back-to-back same-address hazards are resolved by forwarding.
- Supports a whole-array zero sweep on command and automatically after reset, plus a stall-safe readout port.
- Sits between the event/correlation front end and the result readout logic.

Parameters:
- datBit, 17, bin data width minus 1.
- addrBit, 9, bin address width minus 1 (depth = 2^(addrBit+1)).
- incBit, 3, increment value width minus 1 (incBit <= datBit).
- totUnits, 31, number of units minus 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle pulse: start zero sweep of all units.
- inc_v  in  totUnits+1  per-unit increment valid.
- inc_a  in  (addrBit+1) x (totUnits+1)  per-unit bin address.
- inc_d  in  (incBit+1) x (totUnits+1)  per-unit increment value.
- rd_v  in  1  readout request (all units, same address).
- rd_a  in  addrBit+1  readout address.
- rd_rdy  out  1  readout request will be accepted this cycle.
- rd_dv  out  1  readout data valid.
- rd_d  out  (datBit+1) x (totUnits+1)  readout data, one word per unit.
- busy  out  1  zero sweep in progress.
- drop_cnt  out  16  saturating count of increments discarded during a sweep.

Behaviour:
- Reset (RSTn low, asynchronous):
  - All pipeline valids = 0, rd_dv = 0, rd_d = 0, drop_cnt = 0, sweep counter = 0, busy = 1.
  - RAM contents are not reset.
- States: SWEEP, RUN.
  - After RSTn deassertion the block is in SWEEP.
  - SWEEP writes 0 to address = sweep counter in every unit each cycle, for 2^(addrBit+1) cycles.
  - After the write to the all-ones address: counter <= 0, busy <= 0, state <= RUN.
  - clr in RUN: enter SWEEP next cycle; any in-flight S1 write completes first, in the same cycle as the first sweep write at a different address, or is overwritten if it targets address 0.
  - clr during SWEEP: restarts the counter at 0.
- During SWEEP:
  - inc_v is ignored.
  - Each cycle with any inc_v bit set adds popcount(inc_v) to drop_cnt, saturating at 0xFFFF.
  - rd_rdy = 0.
- Increment pipeline per unit, RUN only:
  - S0 (cycle t): inc_v, inc_a and inc_d are registered and the RAM read is issued.
  - S1 (t+1): RAM data is valid. sum = old + zero-extended inc_d, saturating at all-ones of datBit+1. sum is written to the S1 address at the end of t+1.
  - Throughput is 1 increment per unit per cycle. Nothing is ever dropped in RUN.
- Hazard forwarding:
  - If the S0 address at t+1 equals the S1 address at t+1 and both are valid, the S0 read returns stale data.
  - In that case a forward flag is registered, and at t+2 S1 uses the registered previous sum instead of the RAM output.
  - Chains of any length at the same address accumulate exactly.
  - Non-adjacent repeats need no forwarding: the write has landed.
- Readout:
  - rd_rdy = RUN & ~(|inc_v) & no S1 write pending. A unit's read port is shared with S0.
  - rd_v & rd_rdy at cycle t gives rd_dv = 1 and rd_d = bin contents at cycle t+1 (1-cycle latency).
  - rd_v without rd_rdy is ignored; the requester retries.
- Arithmetic: unsigned. Saturation is sticky only through the stored value: increments into a saturated bin leave it saturated.
- inc_a out of range cannot occur (full-width address).

Decomposition:
- Shared package: the state enum {SWEEP, RUN} and the drop-counter width constant.
- One natural sub-module: acc_bram_unit, holding one RAM, the S0/S1 pipeline, forwarding and saturation. It is instantiated totUnits+1 times in a generate loop.
- Sweep FSM, drop_cnt and readout arbitration live in the top level.

Test Plan:
- Release RSTn, wait 2^(addrBit+1) cycles -> busy falls exactly then; reading addr 0, 5 and max in all units -> 0.
- Unit 3: inc addr 7 with d=1 on 4 consecutive cycles, then idle and read addr 7 -> 4 (forwarding chain); unit 4 at addr 7 -> 0.
- Unit 0: inc addr 2 (d=5), addr 9 (d=3), addr 2 (d=2) on consecutive cycles -> read addr 2 = 7, addr 9 = 3.
- Saturation, datBit=3, incBit=3: inc d=15 then d=15 at same address -> bin = 15.
- clr after loading bins, then inc_v all-ones for 2 cycles during the sweep -> all bins 0 after busy falls, drop_cnt = 64 (default totUnits).
- rd_v asserted while inc_v active -> rd_rdy = 0, no rd_dv; rd_v accepted the cycle after inc_v and S1 go idle -> rd_dv one cycle later with correct data.
